// File: rtl/motion_scheduler_if.sv
// Keypad / collision-checker bundle for motion_scheduler.
//   key          raw keypad, active-high: [3]=left [2]=right [1]=forward [0]=backward
//   chk_ack/ok   checker done strobe and verdict (1 = move allowed)
//   chk_req/dir  request to the checker and the direction under check (00=L 01=R 10=F 11=B)
//   rotate_sig   [1]=left step pulse, [0]=right step pulse
//   move_sig     [1]=forward step pulse, [0]=backward step pulse
//   busy         scheduler not idle
//   timeout_err  one-cycle pulse when the checker never answered
// slave: the scheduler side. master: the keypad/checker/tracer side.
interface motion_scheduler_if;
  logic [3:0] key;
  logic       chk_ack;
  logic       chk_ok;
  logic       chk_req;
  logic [1:0] chk_dir;
  logic [1:0] rotate_sig;
  logic [1:0] move_sig;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  key, chk_ack, chk_ok,
    output chk_req, chk_dir, rotate_sig, move_sig, busy, timeout_err
  );

  modport master (
    output key, chk_ack, chk_ok,
    input  chk_req, chk_dir, rotate_sig, move_sig, busy, timeout_err
  );
endinterface

// File: rtl/motion_scheduler.sv
// Debounces the 4-bit direction keypad, records one pending request per press, grants
// pending directions round-robin (L,R,F,B) and runs a req/ack handshake with the
// collision checker for each grant. Approved requests emit a one-cycle step pulse,
// every completed handshake is followed by a STEP_GAP-cycle gap.
// Ports:
//   clk     system clock
//   rst     asynchronous, active-low reset
//   bus_io  motion_scheduler_if.slave (keys, checker handshake, step pulses, status)
// Optional feature: define REPEAT_EN to auto-repeat a held direction REPEAT_CYC cycles
// after its last grant. Without it, each press yields exactly one request.
// Keys are assumed to be synchronous to clk already.
module motion_scheduler #(
  parameter int unsigned DB_CYCLES  = 1000,
  parameter int unsigned STEP_GAP   = 50000,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned REPEAT_CYC = 200000
) (
  input logic               clk,
  input logic               rst,
  motion_scheduler_if.slave bus_io
);

  localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
  localparam int unsigned CntMax = (STEP_GAP > TIMEOUT) ? STEP_GAP : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StReq, StStep, StGap} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [3:0]             db_q, db_d;
  logic [3:0][DbW-1:0]    db_cnt_q, db_cnt_d;
  logic [3:0]             pend_q, pend_d;     // indexed by direction code
  logic [1:0]             ptr_q, ptr_d;       // last granted direction, also drives chk_dir
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic                   tmo_q, tmo_d;
  logic [3:0]             step_q, step_d;     // {rotate_sig, move_sig}

  logic [3:0] key_rise, press, held, rep_set;
  logic       grant_vld, take, tmo_hit;
  logic [1:0] grant_dir;

  // Debounce: db flips only after DB_CYCLES consecutive mismatching samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus_io.key[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Remap key bits to direction codes; a press on an axis whose two keys are both
  // down is ignored.
  assign key_rise = db_d & ~db_q;
  assign press = {key_rise[0] & ~(db_d[1] & db_d[0]),
                  key_rise[1] & ~(db_d[1] & db_d[0]),
                  key_rise[2] & ~(db_d[3] & db_d[2]),
                  key_rise[3] & ~(db_d[3] & db_d[2])};
  assign held  = {db_q[0], db_q[1], db_q[2], db_q[3]};

  // Round-robin: scan from ptr+4 (== ptr, lowest priority) down to ptr+1 so the
  // nearest pending direction after the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_dir = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      if (pend_q[ptr_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_dir = ptr_q + 2'(k);
      end
    end
  end

`ifdef REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYC + 1);

  logic [3:0][RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic [3:0]           rep_arm_q, rep_arm_d;

  // Timer starts at 1 on the grant cycle so the pending bit is visible exactly
  // REPEAT_CYC cycles after the grant.
  always_comb begin
    rep_set   = '0;
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    for (int d = 0; d < 4; d++) begin
      if (!held[d]) begin
        rep_arm_d[d] = 1'b0;
        rep_cnt_d[d] = '0;
      end else if (take && (grant_dir == 2'(d))) begin
        rep_arm_d[d] = 1'b1;
        rep_cnt_d[d] = RepW'(1);
      end else if (rep_arm_q[d]) begin
        if (rep_cnt_q[d] == RepW'(REPEAT_CYC - 1)) begin
          rep_set[d]   = 1'b1;
          rep_arm_d[d] = 1'b0;
          rep_cnt_d[d] = '0;
        end else begin
          rep_cnt_d[d] = rep_cnt_q[d] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q <= '0;
      rep_arm_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_CYC, held};
  assign rep_set       = '0;
`endif

  // Set wins over the grant clear.
  always_comb begin
    pend_d = pend_q;
    if (take) pend_d[grant_dir] = 1'b0;
    pend_d = pend_d | press | rep_set;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          take    = 1'b1;
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (bus_io.chk_ack) begin
          state_d = bus_io.chk_ok ? StStep : StGap;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStep: begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == CntW'(STEP_GAP - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, registered so they track the state register.
  always_comb begin
    ptr_d  = take ? grant_dir : ptr_q;
    req_d  = (state_d == StReq);
    busy_d = (state_d != StIdle);
    tmo_d  = tmo_hit;
    step_d = (state_d == StStep) ? (4'b1000 >> ptr_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      db_q     <= '0;
      db_cnt_q <= '0;
      pend_q   <= '0;
      ptr_q    <= 2'b00;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      step_q   <= step_d;
    end
  end

  assign bus_io.chk_req     = req_q;
  assign bus_io.chk_dir     = ptr_q;
  assign bus_io.rotate_sig  = step_q[3:2];
  assign bus_io.move_sig    = step_q[1:0];
  assign bus_io.busy        = busy_q;
  assign bus_io.timeout_err = tmo_q;

endmodule

// File: tb/tb_motion_scheduler.sv
// Testbench for motion_scheduler: directed scenarios plus randomized key batches
// checked against a transaction-level timing model.
module tb_motion_scheduler;
  localparam int DB = 4, GAP = 8, TMO = 16, REP = 40;
  localparam int EvReq = 0, EvPulse = 1, EvTmo = 2;

  typedef struct packed {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  motion_scheduler_if bus ();

  motion_scheduler #(
    .DB_CYCLES (DB),
    .STEP_GAP  (GAP),
    .TIMEOUT   (TMO),
    .REPEAT_CYC(REP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0, n_fail = 0;
  int  cyc = 0, age = 0, cur_delay = 0, cur_dir = 0, dir_unstable = 0;
  bit  cur_ok = 0, req_prev = 0;
  ev_t obs_q[$], exp_q[$];
  int  resp_delay_q[$];
  bit  resp_ok_q[$];
  bit  busy_hist[int], req_hist[int];

  function automatic ev_t mk_ev(int c, int k, int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    return e;
  endfunction

  // One clock: sample at the falling edge, log events, then drive the checker
  // response for the next rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    busy_hist[cyc] = bus.busy;
    req_hist[cyc]  = bus.chk_req;
    if (bus.chk_req) begin
      if (!req_prev) begin
        age     = 0;
        cur_dir = int'(bus.chk_dir);
        if (resp_delay_q.size() > 0) begin
          cur_delay = resp_delay_q.pop_front();
          cur_ok    = resp_ok_q.pop_front();
        end else begin
          cur_delay = 1000;
          cur_ok    = 1'b0;
        end
        obs_q.push_back(mk_ev(cyc, EvReq, int'(bus.chk_dir)));
      end else begin
        age++;
        if (int'(bus.chk_dir) != cur_dir) dir_unstable++;
      end
    end
    req_prev = bus.chk_req;
    if ({bus.rotate_sig, bus.move_sig} != 4'b0000)
      obs_q.push_back(mk_ev(cyc, EvPulse, int'({bus.rotate_sig, bus.move_sig})));
    if (bus.timeout_err) obs_q.push_back(mk_ev(cyc, EvTmo, 0));
    bus.chk_ack = bus.chk_req && (age == cur_delay);
    bus.chk_ok  = bus.chk_ack && cur_ok;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    resp_delay_q.delete();
    resp_ok_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.key = 4'b0; bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
    run(3);
    n_cmp++;
    if ({bus.chk_req, bus.chk_dir, bus.rotate_sig, bus.move_sig, bus.busy, bus.timeout_err}
        !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {bus.chk_req, bus.chk_dir,
               bus.rotate_sig, bus.move_sig, bus.busy, bus.timeout_err});
    end
    rst = 1'b1;
    run(6);
    n_cmp++;
    if (obs_q.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got events=%0d busy=%b want 0/0", obs_q.size(), bus.busy);
    end
  endtask

  task automatic test_single_press();
    int p;
    clear_logs();
    resp_delay_q.push_back(2); resp_ok_q.push_back(1'b1);
    p = cyc;
    bus.key = 4'b1000;
    run(10);
    bus.key = 4'b0000;
    run(30);
    exp_q.push_back(mk_ev(p + DB + 1, EvReq, 0));
    exp_q.push_back(mk_ev(p + DB + 4, EvPulse, 4'b1000));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL single_ev%0d: got c=%0d k=%0d v=%0d want c=%0d k=%0d v=%0d", k,
                 obs_q[k].cyc, obs_q[k].kind, obs_q[k].val,
                 exp_q[k].cyc, exp_q[k].kind, exp_q[k].val);
      end
    end
    n_cmp++;
    if (busy_hist[p + DB + 4 + GAP] !== 1'b1 || busy_hist[p + DB + 5 + GAP] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: got busy %b,%b want 1,0", busy_hist[p + DB + 4 + GAP],
               busy_hist[p + DB + 5 + GAP]);
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    bus.key = 4'b0010;
    run(DB - 1);
    bus.key = 4'b0000;
    run(20);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch: got %0d events want 0", obs_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int p;
    clear_logs();
    repeat (2) begin resp_delay_q.push_back(0); resp_ok_q.push_back(1'b1); end
    p = cyc;
    bus.key = 4'b0110;
    run(10);
    bus.key = 4'b0000;
    run(40);
    exp_q.push_back(mk_ev(p + 5, EvReq, 1));
    exp_q.push_back(mk_ev(p + 6, EvPulse, 4'b0100));
    exp_q.push_back(mk_ev(p + 16, EvReq, 2));
    exp_q.push_back(mk_ev(p + 17, EvPulse, 4'b0010));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL simul_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL simul_ev%0d: got c=%0d k=%0d v=%0d want c=%0d k=%0d v=%0d", k,
                 obs_q[k].cyc, obs_q[k].kind, obs_q[k].val,
                 exp_q[k].cyc, exp_q[k].kind, exp_q[k].val);
      end
    end
    n_cmp++;
    if (busy_hist[p + 15] !== 1'b0 || busy_hist[p + 25] !== 1'b1 || busy_hist[p + 26] !== 1'b0)
    begin
      n_fail++;
      $display("FAIL simul_gap: got busy %b%b%b want 010", busy_hist[p + 15],
               busy_hist[p + 25], busy_hist[p + 26]);
    end
  endtask

  task automatic test_timeout();
    int p;
    clear_logs();
    p = cyc;
    bus.key = 4'b0001;
    run(10);
    bus.key = 4'b0000;
    run(30);
    exp_q.push_back(mk_ev(p + 5, EvReq, 3));
    exp_q.push_back(mk_ev(p + 5 + TMO, EvTmo, 0));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL tmo_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL tmo_ev%0d: got c=%0d k=%0d v=%0d want c=%0d k=%0d v=%0d", k,
                 obs_q[k].cyc, obs_q[k].kind, obs_q[k].val,
                 exp_q[k].cyc, exp_q[k].kind, exp_q[k].val);
      end
    end
    n_cmp++;
    if (req_hist[p + 4 + TMO] !== 1'b1 || req_hist[p + 5 + TMO] !== 1'b0 ||
        busy_hist[p + 5 + TMO] !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_len: got req %b,%b busy %b want 1,0 busy 0", req_hist[p + 4 + TMO],
               req_hist[p + 5 + TMO], busy_hist[p + 5 + TMO]);
    end
  endtask

  task automatic test_reject_and_reset();
    int p;
    clear_logs();
    resp_delay_q.push_back(1); resp_ok_q.push_back(1'b0);
    p = cyc;
    bus.key = 4'b0100;
    run(10);
    bus.key = 4'b0000;
    run(20);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== mk_ev(p + 5, EvReq, 1)) begin
      n_fail++;
      $display("FAIL reject_events: got %0d events want 1 request only", obs_q.size());
    end
    n_cmp++;
    if (busy_hist[p + 14] !== 1'b1 || busy_hist[p + 15] !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_gap: got busy %b,%b want 1,0", busy_hist[p + 14], busy_hist[p + 15]);
    end
    // Two directions pressed: one goes to REQ (no ack), the other stays pending.
    clear_logs();
    p = cyc;
    bus.key = 4'b0110;
    run(5);
    bus.key = 4'b0000;
    run(3);
    n_cmp++;
    if (req_hist[p + 8] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreq_setup: got chk_req %b want 1", req_hist[p + 8]);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.chk_req, bus.chk_dir, bus.rotate_sig, bus.move_sig, bus.busy, bus.timeout_err}
        !== 9'b0) begin
      n_fail++;
      $display("FAIL midreq_reset: got %b want 0", {bus.chk_req, bus.chk_dir,
               bus.rotate_sig, bus.move_sig, bus.busy, bus.timeout_err});
    end
    run(2);
    clear_logs();
    rst = 1'b1;
    run(30);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_cleared: got %0d events want 0", obs_q.size());
    end
  endtask

  task automatic test_repeat();
    int p;
    clear_logs();
    repeat (5) begin resp_delay_q.push_back(0); resp_ok_q.push_back(1'b1); end
    p = cyc;
    bus.key = 4'b0010;
    run(100);
    bus.key = 4'b0000;
    run(60);
    exp_q.push_back(mk_ev(p + 5, EvReq, 2));
    exp_q.push_back(mk_ev(p + 6, EvPulse, 4'b0010));
`ifdef REPEAT_EN
    for (int r = 1; r <= 2; r++) begin
      exp_q.push_back(mk_ev(p + 5 + r * REP, EvReq, 2));
      exp_q.push_back(mk_ev(p + 6 + r * REP, EvPulse, 4'b0010));
    end
`endif
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL repeat_ev%0d: got c=%0d k=%0d v=%0d want c=%0d k=%0d v=%0d", k,
                 obs_q[k].cyc, obs_q[k].kind, obs_q[k].val,
                 exp_q[k].cyc, exp_q[k].kind, exp_q[k].val);
      end
    end
  endtask

  // Random key batches; the model derives the grant order and event timing from the
  // round-robin rule and the handshake/gap durations.
  task automatic test_random();
    int  p, hold, t, idle, ptr, run_len, d;
    int  dl[4];
    bit  okv[4];
    bit  pend[4];
    logic [3:0] mask;
    bit  found;
    rst = 1'b0;
    run(2);
    rst = 1'b1;
    run(2);
    ptr = 0;
    dir_unstable = 0;
    for (int b = 0; b < 25; b++) begin
      clear_logs();
      mask = 4'($urandom_range(1, 15));
      hold = $urandom_range(DB - 1, 30);
      for (int k = 0; k < 4; k++) begin
        dl[k]  = $urandom_range(0, TMO + 4);
        okv[k] = 1'($urandom_range(0, 1));
        resp_delay_q.push_back(dl[k]);
        resp_ok_q.push_back(okv[k]);
      end
      p = cyc;
      bus.key = mask;
      for (int k = 0; k < 4; k++) pend[k] = (hold >= DB) && mask[3 - k];
      if (pend[0] && pend[1]) begin pend[0] = 0; pend[1] = 0; end
      if (pend[2] && pend[3]) begin pend[2] = 0; pend[3] = 0; end
      t = p + DB + 1;
      idle = p;
      for (int g = 0; g < 4; g++) begin
        found = 0;
        d = 0;
        for (int s = 1; s <= 4; s++) begin
          if (!found && pend[(ptr + s) % 4]) begin found = 1; d = (ptr + s) % 4; end
        end
        if (found) begin
          ptr = d;
          pend[d] = 0;
          exp_q.push_back(mk_ev(t, EvReq, d));
          if (dl[g] < TMO) begin
            if (okv[g]) begin
              exp_q.push_back(mk_ev(t + dl[g] + 1, EvPulse, 8 >> d));
              idle = t + dl[g] + 2 + GAP;
            end else begin
              idle = t + dl[g] + 1 + GAP;
            end
          end else begin
            exp_q.push_back(mk_ev(t + TMO, EvTmo, 0));
            idle = t + TMO;
          end
          t = idle + 1;
        end
      end
      run_len = ((idle - p) > hold ? (idle - p) : hold) + DB + 4;
      for (int c = 1; c <= run_len; c++) begin
        cycle();
        if (c == hold) bus.key = 4'b0000;
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: mask=%b hold=%0d got %0d events want %0d", b, mask, hold,
                 obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand%0d_ev%0d: got c=%0d k=%0d v=%0d want c=%0d k=%0d v=%0d", b, k,
                   obs_q[k].cyc, obs_q[k].kind, obs_q[k].val,
                   exp_q[k].cyc, exp_q[k].kind, exp_q[k].val);
        end
      end
    end
    n_cmp++;
    if (dir_unstable != 0) begin
      n_fail++;
      $display("FAIL chk_dir_stable: got %0d changes want 0", dir_unstable);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_timeout();
    test_reject_and_reset();
    test_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
